spi_flash_rd_seq: RTL

//  Wishbone-master sequencer that drives the 8-bit SPI master core to perform serial-flash

---
 rtl/spi_flash_rd_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: Wishbone-master sequencer that drives the 8-bit SPI master
// core through a serial-flash READ: select on, opcode, 24-bit address, N data
// bytes streamed out on a valid/ready port, select off.
module spi_flash_rd_seq #(
    parameter int         CS_SEL   = 0,
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         LEN_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [15:0]      m_dat_o,
    input  logic [7:0]       m_dat_i,
    output logic             m_we_o,
    output logic [1:0]       m_sel_o,
    output logic             m_stb_o,
    output logic             m_cyc_o,
    input  logic             m_ack_i
);

    // Slave-select register value with only the chosen select driven low.
    localparam logic [7:0] SS_ON = ~(8'h01 << CS_SEL);
    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_CS_ON, S_CMD, S_ADR, S_DATA, S_HOLD, S_CS_OFF, S_FIN
    } state_t;

    state_t           state_reg, state_next;
    logic             gap_reg, gap_next;          // 1 = mandatory idle cycle after an ack
    logic [23:0]      addr_reg, addr_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;          // bytes still to deliver
    logic [1:0]       adr_idx_reg, adr_idx_next;  // which address byte is on the bus
    logic             abort_reg, abort_next;      // abort seen earlier in this transaction
    logic             xfer_reg, xfer_next;        // a real (len != 0) transaction is running
    logic [7:0]       rd_data_reg, rd_data_next;
    logic             rd_valid_reg, rd_valid_next;

    logic             abort_seen;
    logic             stb;
    logic [1:0]       sel;
    logic [15:0]      dat;

    assign abort_seen = abort_reg | abort;

    // State and datapath registers, cleared asynchronously so a reset kills any transfer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg    <= S_IDLE;
            gap_reg      <= 1'b0;
            addr_reg     <= 24'h0;
            cnt_reg      <= '0;
            adr_idx_reg  <= 2'd0;
            abort_reg    <= 1'b0;
            xfer_reg     <= 1'b0;
            rd_data_reg  <= 8'h00;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gap_reg      <= gap_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
            adr_idx_reg  <= adr_idx_next;
            abort_reg    <= abort_next;
            xfer_reg     <= xfer_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    // Next-state logic and bus outputs; every bus state is issue -> wait ack -> gap.
    always_comb begin
        state_next    = state_reg;
        gap_next      = gap_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        adr_idx_next  = adr_idx_reg;
        abort_next    = abort_reg;
        xfer_next     = xfer_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = rd_valid_reg;
        stb           = 1'b0;
        sel           = 2'b00;
        dat           = 16'h0000;

        if (busy && abort) begin
            abort_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next    = addr;
                    cnt_next     = len;
                    adr_idx_next = 2'd0;
                    abort_next   = 1'b0;
                    gap_next     = 1'b0;
                    if (len != '0) begin
                        xfer_next  = 1'b1;
                        state_next = S_CS_ON;
                    end else begin
                        xfer_next  = 1'b0;
                        state_next = S_FIN;
                    end
                end
            end

            S_CS_ON, S_CMD, S_ADR, S_DATA, S_CS_OFF: begin
                if (!gap_reg) begin
                    stb = 1'b1;
                    case (state_reg)
                        S_CS_ON: begin
                            sel = 2'b10;
                            dat = {SS_ON, 8'hFF};
                        end
                        S_CMD: begin
                            sel = 2'b01;
                            dat = {8'hFF, READ_CMD};
                        end
                        S_ADR: begin
                            sel = 2'b01;
                            case (adr_idx_reg)
                                2'd0:    dat = {8'hFF, addr_reg[23:16]};
                                2'd1:    dat = {8'hFF, addr_reg[15:8]};
                                default: dat = {8'hFF, addr_reg[7:0]};
                            endcase
                        end
                        S_DATA: begin
                            sel = 2'b01;
                            dat = 16'hFFFF;
                        end
                        default: begin
                            sel = 2'b10;
                            dat = 16'hFFFF;
                        end
                    endcase
                    if (m_ack_i) begin
                        if (state_reg == S_DATA && !abort_seen) begin
                            // HOLD has no bus access, so it already provides the idle gap.
                            rd_data_next  = m_dat_i;
                            rd_valid_next = 1'b1;
                            state_next    = S_HOLD;
                        end else begin
                            gap_next = 1'b1;
                        end
                    end
                end else begin
                    gap_next = 1'b0;
                    case (state_reg)
                        S_CS_ON:  state_next = abort_seen ? S_CS_OFF : S_CMD;
                        S_CMD:    state_next = abort_seen ? S_CS_OFF : S_ADR;
                        S_ADR: begin
                            if (abort_seen) begin
                                state_next = S_CS_OFF;
                            end else if (adr_idx_reg == 2'd2) begin
                                state_next = S_DATA;
                            end else begin
                                adr_idx_next = adr_idx_reg + 2'd1;
                            end
                        end
                        // Only reached when the byte was discarded by an abort.
                        S_DATA:   state_next = S_CS_OFF;
                        default:  state_next = S_FIN;
                    endcase
                end
            end

            S_HOLD: begin
                if (abort_seen) begin
                    rd_valid_next = 1'b0;
                    state_next    = S_CS_OFF;
                end else if (rd_valid_reg && rd_ready) begin
                    rd_valid_next = 1'b0;
                    cnt_next      = cnt_reg - ONE;
                    state_next    = (cnt_reg == ONE) ? S_CS_OFF : S_DATA;
                end
            end

            S_FIN: begin
                xfer_next  = 1'b0;
                state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign busy     = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done     = (state_reg == S_FIN);
    assign aborted  = (state_reg == S_FIN) && (abort_reg || (abort && xfer_reg));
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign m_stb_o  = stb;
    assign m_cyc_o  = stb;
    assign m_we_o   = stb;
    assign m_sel_o  = sel;
    assign m_dat_o  = dat;

endmodule
